skinny_round_ctrl: RTL and testbench

Round sequencer for the byte-serial Skinny-128-384+ core inside the Romulus-N datapath. The mode controller hands it one block-cipher call through a valid/ready start handshake. The block then sequences ROUNDS rounds, each made of 16 byte-shift (SubCells/AddConstant/AddRoundTweakey) cycles followed by MXC_CYCLES MixColumns cycles. It generates the state and tweakey enables, the round-constant byte and a one-cycle done pulse.

---
 rtl/skinny_round_ctrl.sv | 116 +++++++++++
 tb/tb_skinny_round_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_round_ctrl.sv
// Round sequencer for the byte-serial Skinny-128-384+ core: per round, 16 byte-shift cycles
// then MXC_CYCLES MixColumns cycles, with round constants and a one-cycle done pulse.
module skinny_round_ctrl #(
  parameter int unsigned ROUNDS     = 40,
  parameter int unsigned MXC_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       stall,
  output logic       sen,
  output logic       tkse,
  output logic       tkksch,
  output logic       smxc,
  output logic [7:0] con,
  output logic [3:0] byte_idx,
  output logic [5:0] round,
  output logic       last_round,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);
  localparam logic [3:0] LastMxc   = 4'(MXC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSb, StMc, StDone} state_e;

  state_e     state;
  logic [3:0] mxc_cnt;
  logic [5:0] rc;
  logic [5:0] rc_next;
  logic       run_sb;
  logic       run_mc;

  assign rc_next = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      byte_idx <= 4'd0;
      mxc_cnt  <= 4'd0;
      round    <= 6'd0;
      rc       <= 6'h01;
    end else begin
      unique case (state)
        StIdle: begin
          if (start_valid) begin
            state    <= StSb;
            byte_idx <= 4'd0;
            mxc_cnt  <= 4'd0;
            round    <= 6'd0;
            rc       <= 6'h01;
          end
        end
        StSb: begin
          if (!stall) begin
            byte_idx <= byte_idx + 4'd1;
            if (byte_idx == 4'hf) begin
              state   <= StMc;
              mxc_cnt <= 4'd0;
            end
          end
        end
        StMc: begin
          if (!stall) begin
            mxc_cnt <= mxc_cnt + 4'd1;
            if (mxc_cnt == LastMxc) begin
              mxc_cnt <= 4'd0;
              if (round == LastRound) begin
                state <= StDone;
              end else begin
                round <= round + 6'd1;
                rc    <= rc_next;
                state <= StSb;
              end
            end
          end
        end
        StDone: begin
          // Clear the counters on the way out so every IDLE output reads zero.
          state    <= StIdle;
          byte_idx <= 4'd0;
          mxc_cnt  <= 4'd0;
          round    <= 6'd0;
          rc       <= 6'h01;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign run_sb      = (state == StSb) && !stall;
  assign run_mc      = (state == StMc) && !stall;
  assign start_ready = (state == StIdle);
  assign busy        = (state == StSb) || (state == StMc);
  assign done        = (state == StDone);
  assign sen         = run_sb;
  assign tkse        = run_sb;
  assign tkksch      = run_sb && (byte_idx == 4'hf);
  assign smxc        = run_mc;
  assign last_round  = busy && (round == LastRound);

  always_comb begin
    con = 8'h00;
    if (run_sb) begin
      case (byte_idx)
        4'd0:    con = {4'h0, rc[3:0]};
        4'd4:    con = {6'h00, rc[5:4]};
        4'd8:    con = 8'h02;
        default: con = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Directed bench for skinny_round_ctrl: table of early-call cycles plus latency, stall,
// back-to-back, abort and minimal-parameter sequences.
module tb_skinny_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_valid = 1'b0;
  logic       stall = 1'b0;
  logic       start_ready, sen, tkse, tkksch, smxc, last_round, busy, done;
  logic [7:0] con;
  logic [3:0] byte_idx;
  logic [5:0] round;

  logic       start_valid_s = 1'b0;
  logic       stall_s = 1'b0;
  logic       start_ready_s, sen_s, tkse_s, tkksch_s, smxc_s, last_round_s, busy_s, done_s;
  logic [7:0] con_s;
  logic [3:0] byte_idx_s;
  logic [5:0] round_s;

  skinny_round_ctrl u_dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .stall(stall), .sen(sen), .tkse(tkse), .tkksch(tkksch), .smxc(smxc), .con(con),
    .byte_idx(byte_idx), .round(round), .last_round(last_round), .busy(busy), .done(done)
  );

  skinny_round_ctrl #(.ROUNDS(1), .MXC_CYCLES(1)) u_small (
    .clk(clk), .rst(rst), .start_valid(start_valid_s), .start_ready(start_ready_s),
    .stall(stall_s), .sen(sen_s), .tkse(tkse_s), .tkksch(tkksch_s), .smxc(smxc_s),
    .con(con_s), .byte_idx(byte_idx_s), .round(round_s), .last_round(last_round_s),
    .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle expectations for the first cycles after acceptance.
  typedef struct {
    logic       stall;
    logic       sen;
    logic       tkksch;
    logic       smxc;
    logic [7:0] con;
    logic [3:0] bidx;
    logic [5:0] rnd;
  } vec_t;
  vec_t vec [24];

  // Monitors
  int  cyc = 0;
  int  acc_q [$];
  bit  mon_en = 0;
  int  sen_n = 0, smxc_n = 0, tkksch_n = 0, lr_bad = 0;
  logic [7:0] con_r5_b0 = 8'hxx, con_r5_b4 = 8'hxx;
  bit  b2b_en = 0;
  int  sr_low_n = 0, done_n = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start_valid && start_ready) acc_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      sen_n    <= sen_n + int'(sen);
      smxc_n   <= smxc_n + int'(smxc);
      tkksch_n <= tkksch_n + int'(tkksch);
      if (sen && round == 6'd5 && byte_idx == 4'd0) con_r5_b0 <= con;
      if (sen && round == 6'd5 && byte_idx == 4'd4) con_r5_b4 <= con;
      if (busy && (last_round != (round == 6'd39))) lr_bad <= lr_bad + 1;
    end
    if (b2b_en) begin
      sr_low_n <= sr_low_n + int'(!start_ready);
      done_n   <= done_n + int'(done);
    end
  end

  task automatic accept();
    start_valid = 1'b1;
    @(posedge clk); #2;
    start_valid = 1'b0;
  endtask

  // Entered 2 time units after an edge, k cycles after acceptance; runs to the done pulse.
  task automatic finish_call(input int k_start, input int exp_k, input string name);
    int k;
    bit seen;
    k = k_start;
    seen = 0;
    stall = 1'b0;
    while (!seen && k < 3000) begin
      #1;
      if (done === 1'b1) seen = 1;
      else begin
        @(posedge clk); #2;
        k++;
      end
    end
    check({name, " latency"}, k, exp_k);
    @(posedge clk); #3;
    check({name, " done_width"}, {done, start_ready}, 2'b01);
  endtask

  initial begin
    logic [9:0] hold_exp;
    int k;
    int busy_n;
    int lr_bad_s;

    vec[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 4'd0, 6'd0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 6'd0};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd2, 6'd0};
    for (int i = 3; i <= 16; i++) vec[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'(i - 1), 6'd0};
    vec[9].con     = 8'h02;
    vec[16].tkksch = 1'b1;
    vec[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 6'd0};
    vec[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 6'd0};
    vec[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 6'd0};
    vec[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 6'd0};
    vec[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 6'd0};
    vec[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 4'd0, 6'd1};
    vec[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 6'd1};

    // Reset state
    #13;
    check("reset dut", {sen, tkse, tkksch, smxc, con, byte_idx, round, last_round, busy,
                        done, start_ready}, 26'd1);
    check("reset small", {sen_s, tkse_s, tkksch_s, smxc_s, con_s, byte_idx_s, round_s,
                          last_round_s, busy_s, done_s, start_ready_s}, 26'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #3;
    check("idle", {busy, done, start_ready, round}, {1'b0, 1'b0, 1'b1, 6'd0});

    // Table-driven first cycles (stalls at k=2 and k=18), then full-call latency
    sen_n = 0; smxc_n = 0; tkksch_n = 0; lr_bad = 0;
    mon_en = 1;
    accept();
    for (int i = 0; i < 24; i++) begin
      stall = vec[i].stall;
      #1;
      check($sformatf("vec[%0d]", i),
            {sen, tkse, tkksch, smxc, con, byte_idx, round, busy, done, start_ready},
            {vec[i].sen, vec[i].sen, vec[i].tkksch, vec[i].smxc, vec[i].con, vec[i].bidx,
             vec[i].rnd, 1'b1, 1'b0, 1'b0});
      @(posedge clk); #2;
    end
    finish_call(24, 802, "table");
    mon_en = 0;
    #1;
    check("sen count", sen_n, 640);
    check("smxc count", smxc_n, 160);
    check("tkksch count", tkksch_n, 40);
    check("con r5 b0", con_r5_b0, 8'h0e);
    check("con r5 b4", con_r5_b4, 8'h03);
    check("last_round", lr_bad, 0);

    // Stalls in round 2 MC (7 cycles) and at round 3 byte 4 (3 cycles)
    accept();
    for (int kk = 0; kk <= 74; kk++) begin
      stall = ((kk >= 57) && (kk <= 63)) || ((kk >= 71) && (kk <= 73));
      #1;
      if (stall) begin
        hold_exp = (kk < 64) ? {6'd2, 4'd0} : {6'd3, 4'd4};
        check("stall gate", {sen, tkse, tkksch, smxc, con, busy}, {12'h000, 1'b1});
        check("stall hold", {round, byte_idx}, hold_exp);
      end
      if (kk == 64) check("post stall mc", {smxc, round}, {1'b1, 6'd2});
      if (kk == 74) check("post stall sb", {sen, round, byte_idx}, {1'b1, 6'd3, 4'd4});
      @(posedge clk); #2;
    end
    finish_call(75, 810, "stall");

    // Back-to-back with start_valid held high
    acc_q.delete();
    start_valid = 1'b1;
    @(posedge clk); #2;
    sr_low_n = 0; done_n = 0;
    b2b_en = 1;
    k = 0;
    while (acc_q.size() < 2 && k < 2000) begin
      @(posedge clk); #2;
      k++;
    end
    b2b_en = 0;
    start_valid = 1'b0;
    check("b2b accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) check("b2b spacing", acc_q[1] - acc_q[0], 802);
    check("b2b ready low", sr_low_n, 801);
    check("b2b done width", done_n, 1);
    finish_call(0, 800, "b2b second");

    // Abort during round 17 SB byte 9
    accept();
    for (int kk = 0; kk < 349; kk++) begin
      @(posedge clk); #2;
    end
    #1;
    check("pre abort", {sen, round, byte_idx}, {1'b1, 6'd17, 4'd9});
    rst = 1'b0;
    #1;
    check("abort async", {sen, tkse, tkksch, smxc, con, byte_idx, round, last_round, busy,
                          done, start_ready}, 26'd1);
    @(negedge clk); rst = 1'b1;
    for (int kk = 0; kk < 3; kk++) begin
      @(posedge clk); #3;
      check("after abort", {done, start_ready, round}, {1'b0, 1'b1, 6'd0});
    end
    accept();
    #1;
    check("restart con", {con, round}, {8'h01, 6'd0});
    @(posedge clk); #2;
    finish_call(1, 800, "restart");

    // Minimal build: ROUNDS=1, MXC_CYCLES=1
    start_valid_s = 1'b1;
    @(posedge clk); #2;
    start_valid_s = 1'b0;
    k = 0; busy_n = 0; lr_bad_s = 0;
    while (k < 100) begin
      #1;
      if (done_s) break;
      if (busy_s) begin
        busy_n++;
        if (!last_round_s) lr_bad_s++;
      end
      @(posedge clk); #2;
      k++;
    end
    check("small latency", k, 17);
    check("small busy", busy_n, 17);
    check("small last_round", lr_bad_s, 0);
    @(posedge clk); #3;
    check("small idle", {done_s, start_ready_s}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
